// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcodes understood by the pixel generator and the
// scheduler FSM state encoding.
package gpu_pkg;

  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_FILL      = 8'h02;
  localparam logic [7:0] OP_LINE      = 8'h03;
  localparam logic [7:0] OP_RECT      = 8'h04;
  localparam logic [7:0] OP_BLIT      = 8'h05;
  localparam logic [7:0] OP_PALETTE   = 8'h06;
  localparam logic [7:0] OP_SET_PIXEL = 8'h07;
  localparam logic [7:0] OPCODE_MAX   = OP_SET_PIXEL;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_GAP        = 2'd2
  } sched_state_e;

  function automatic logic opcode_is_valid(input logic [7:0] op);
    return (op != 8'h00) && (op <= OPCODE_MAX);
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Synchronous word FIFO; power-of-two depth so the pointers wrap for free.
module instruction_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instruction_scheduler.sv
// Two-requester instruction buffer feeding the pixel generator; SET_PIXEL is
// held until blanking and every issue is followed by a fixed idle gap.
module instruction_scheduler
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req0_valid,
  input  logic [31:0]                   i_req0_instr,
  output logic                          o_req0_ready,
  input  logic                          i_req1_valid,
  input  logic [31:0]                   i_req1_instr,
  output logic                          o_req1_ready,
  input  logic                          i_hblank,
  input  logic                          i_vblank,
  output logic [31:0]                   o_instruction,
  output logic                          o_instruction_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [7:0]                    o_drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam sched_state_e POST_ISSUE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic          grant0_s;
  logic          grant1_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;
  logic          drop_s;
  logic          blank_s;
  logic          full_s;
  logic          empty_s;
  logic          last_req0_r;
  logic [31:0]   push_data_s;
  logic [31:0]   head_s;
  logic [7:0]    head_op_s;
  logic [CW-1:0] count_s;
  logic [3:0]    gap_cnt_r;
  sched_state_e  state_r;
  sched_state_e  state_next_s;

  // Round-robin between two requesters: on contention the one not served last wins.
  assign grant0_s     = i_req0_valid & (~i_req1_valid | ~last_req0_r);
  assign grant1_s     = i_req1_valid & ~grant0_s;
  assign o_req0_ready = grant0_s & ~full_s;
  assign o_req1_ready = grant1_s & ~full_s;
  assign push_s       = o_req0_ready | o_req1_ready;
  assign push_data_s  = grant1_s ? i_req1_instr : i_req0_instr;
  assign pop_s        = issue_s | drop_s;
  assign blank_s      = i_hblank | i_vblank;
  assign head_op_s    = head_s[7:0];
  assign o_fifo_count = count_s;

  instruction_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Remember which requester the last transfer served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_req0_r <= 1'b0;
    end else if (push_s) begin
      last_req0_r <= grant0_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && opcode_is_valid(head_op_s)) begin
          if ((head_op_s == OP_SET_PIXEL) && !blank_s) begin
            state_next_s = ST_WAIT_BLANK;
          end else begin
            state_next_s = POST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_BLANK: begin
        if (blank_s) begin
          state_next_s = POST_ISSUE;
        end else begin
          state_next_s = ST_WAIT_BLANK;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 4'd0) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: issue the head word or discard an unknown opcode.
  always_comb begin
    issue_s = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (empty_s) begin
          issue_s = 1'b0;
        end else if (!opcode_is_valid(head_op_s)) begin
          drop_s = 1'b1;
        end else if ((head_op_s != OP_SET_PIXEL) || blank_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_WAIT_BLANK: begin
        if (blank_s && !empty_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_GAP:  issue_s = 1'b0;
      default: issue_s = 1'b0;
    endcase
  end

  // Registered strobe, zeroed instruction bus, gap timer and drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instruction       <= 32'h0;
      o_instruction_ready <= 1'b0;
      o_drop_count        <= 8'h00;
      gap_cnt_r           <= 4'd0;
    end else begin
      o_instruction       <= issue_s ? head_s : 32'h0;
      o_instruction_ready <= issue_s;
      if (drop_s && (o_drop_count != 8'hFF)) begin
        o_drop_count <= o_drop_count + 8'h01;
      end
      if (issue_s) begin
        gap_cnt_r <= GAP_LOAD;
      end else if ((state_r == ST_GAP) && (gap_cnt_r != 4'd0)) begin
        gap_cnt_r <= gap_cnt_r - 4'd1;
      end
    end
  end

endmodule
